// File: rtl/ppu_bg_tile_shifter_if.sv
// rtl/ppu_bg_tile_shifter_if.sv - control/data bundle between tile fetch logic and the bg pixel shifter
interface ppu_bg_tile_shifter_if #(
  parameter int TILE_W    = 8,
  parameter int PLANES    = 2,
  parameter int ATTR_BITS = 2
);
  localparam int FINE_W = $clog2(TILE_W);

  logic                     i_shift_en;
  logic                     i_stage_en;
  logic [PLANES*TILE_W-1:0] i_pat_in;
  logic [ATTR_BITS-1:0]     i_attr_in;
  logic                     i_load_en;
  logic                     i_auto_reload;
  logic                     i_phase_clr;
  logic [FINE_W-1:0]        i_fine_x;
  logic [PLANES-1:0]        o_pixel_out;
  logic [ATTR_BITS-1:0]     o_palette_out;
  logic [FINE_W-1:0]        o_phase;
  logic                     o_reload_pulse;

  modport master (
    output i_shift_en, i_stage_en, i_pat_in, i_attr_in, i_load_en,
           i_auto_reload, i_phase_clr, i_fine_x,
    input  o_pixel_out, o_palette_out, o_phase, o_reload_pulse
  );

  modport slave (
    input  i_shift_en, i_stage_en, i_pat_in, i_attr_in, i_load_en,
           i_auto_reload, i_phase_clr, i_fine_x,
    output o_pixel_out, o_palette_out, o_phase, o_reload_pulse
  );
endinterface

// File: rtl/ppu_bg_tile_shifter.sv
// rtl/ppu_bg_tile_shifter.sv - background pattern/attribute shifter with staging buffer
// and phase-driven auto reload; pixel picked by fine-X scroll.
module ppu_bg_tile_shifter #(
  parameter int TILE_W    = 8,
  parameter int PLANES    = 2,
  parameter int ATTR_BITS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  ppu_bg_tile_shifter_if.slave   bus
);
  localparam int FINE_W = $clog2(TILE_W);

  logic [2*TILE_W-1:0]      r_pat_sr [PLANES];
  logic [TILE_W-1:0]        r_attr_sr [ATTR_BITS];
  logic [PLANES*TILE_W-1:0] r_stg_pat;
  logic [ATTR_BITS-1:0]     r_stg_attr;
  logic [ATTR_BITS-1:0]     r_attr_latch;
  logic [FINE_W-1:0]        r_phase;
  logic                     r_reload_pulse;

  logic                     w_reload;
  logic [FINE_W:0]          w_pat_idx;
  logic [FINE_W-1:0]        w_attr_idx;

  assign w_reload = bus.i_load_en |
                    (bus.i_auto_reload & bus.i_shift_en & (r_phase == FINE_W'(TILE_W - 1)));

  // TILE_W is a power of two, so (2W-1)-fx == {1,~fx} and (W-1)-fx == ~fx.
  assign w_pat_idx  = {1'b1, ~bus.i_fine_x};
  assign w_attr_idx = ~bus.i_fine_x;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < PLANES; p++) r_pat_sr[p] <= '0;
      for (int a = 0; a < ATTR_BITS; a++) r_attr_sr[a] <= '0;
      r_stg_pat      <= '0;
      r_stg_attr     <= '0;
      r_attr_latch   <= '0;
      r_phase        <= '0;
      r_reload_pulse <= 1'b0;
    end else begin
      if (bus.i_stage_en) begin
        r_stg_pat  <= bus.i_pat_in;
        r_stg_attr <= bus.i_attr_in;
      end

      for (int p = 0; p < PLANES; p++) begin
        if (bus.i_shift_en && w_reload)
          r_pat_sr[p] <= {r_pat_sr[p][2*TILE_W-2:TILE_W-1], r_stg_pat[p*TILE_W +: TILE_W]};
        else if (w_reload)
          r_pat_sr[p] <= {r_pat_sr[p][2*TILE_W-1:TILE_W], r_stg_pat[p*TILE_W +: TILE_W]};
        else if (bus.i_shift_en)
          r_pat_sr[p] <= {r_pat_sr[p][2*TILE_W-2:0], 1'b0};
      end

      // Attribute regs are fed serially from the latch as it stood before this edge's reload.
      for (int a = 0; a < ATTR_BITS; a++) begin
        if (bus.i_shift_en)
          r_attr_sr[a] <= {r_attr_sr[a][TILE_W-2:0], r_attr_latch[a]};
      end
      if (w_reload) r_attr_latch <= r_stg_attr;

      if (bus.i_phase_clr)     r_phase <= '0;
      else if (bus.i_shift_en) r_phase <= r_phase + 1'b1;

      r_reload_pulse <= w_reload;
    end
  end

  always_comb begin
    bus.o_pixel_out   = '0;
    bus.o_palette_out = '0;
    for (int p = 0; p < PLANES; p++) bus.o_pixel_out[p] = r_pat_sr[p][w_pat_idx];
    for (int a = 0; a < ATTR_BITS; a++) bus.o_palette_out[a] = r_attr_sr[a][w_attr_idx];
  end

  assign bus.o_phase        = r_phase;
  assign bus.o_reload_pulse = r_reload_pulse;
endmodule

// File: tb/tb_ppu_bg_tile_shifter.sv
// tb/tb_ppu_bg_tile_shifter.sv - directed vector table plus reset sequences for ppu_bg_tile_shifter
module tb_ppu_bg_tile_shifter;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ppu_bg_tile_shifter_if #(.TILE_W(8), .PLANES(2), .ATTR_BITS(2)) bus ();

  ppu_bg_tile_shifter #(.TILE_W(8), .PLANES(2), .ATTR_BITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        sh, st;
    logic [15:0] pat;
    logic [1:0]  attr;
    logic        ld, au, pc;
    logic [2:0]  fx;
    logic [1:0]  e_pix, e_pal;
    logic [2:0]  e_ph;
    logic        e_pul;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(logic sh, logic st, logic [15:0] pat, logic [1:0] attr,
                              logic ld, logic au, logic pc, logic [2:0] fx,
                              logic [1:0] pix, logic [1:0] pal, logic [2:0] ph, logic pul);
    vec_t v;
    v.sh = sh; v.st = st; v.pat = pat; v.attr = attr;
    v.ld = ld; v.au = au; v.pc = pc; v.fx = fx;
    v.e_pix = pix; v.e_pal = pal; v.e_ph = ph; v.e_pul = pul;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_shift_en    = v.sh;
    bus.i_stage_en    = v.st;
    bus.i_pat_in      = v.pat;
    bus.i_attr_in     = v.attr;
    bus.i_load_en     = v.ld;
    bus.i_auto_reload = v.au;
    bus.i_phase_clr   = v.pc;
    bus.i_fine_x      = v.fx;
  endtask

  task automatic check_outs(input string tag, input int idx, input logic [1:0] pix,
                            input logic [1:0] pal, input logic [2:0] ph, input logic pul);
    chk({tag, ".pixel"},   idx, 8'(bus.o_pixel_out),    8'(pix));
    chk({tag, ".palette"}, idx, 8'(bus.o_palette_out),  8'(pal));
    chk({tag, ".phase"},   idx, 8'(bus.o_phase),        8'(ph));
    chk({tag, ".pulse"},   idx, 8'(bus.o_reload_pulse), 8'(pul));
  endtask

  initial begin
    // Tile A: P1=0x3C P0=0xA5 attr 2; tile B: P0=0xFF P1=0x00 attr 1; tile C: P1=0x81 P0=0x0F attr 3.
    vecs[0]  = mk(0,1,16'h3CA5,2, 0,0,0,0, 0,0,0,0);
    vecs[1]  = mk(0,0,16'h0000,0, 1,0,0,0, 0,0,0,1);
    vecs[2]  = mk(1,1,16'h00FF,1, 0,1,0,0, 0,0,1,0);
    vecs[3]  = mk(1,0,16'h0000,0, 0,1,0,0, 0,0,2,0);
    vecs[4]  = mk(1,0,16'h0000,0, 0,1,0,0, 0,0,3,0);
    vecs[5]  = mk(1,0,16'h0000,0, 0,1,0,0, 0,0,4,0);
    vecs[6]  = mk(1,0,16'h0000,0, 0,1,0,0, 0,0,5,0);
    vecs[7]  = mk(1,0,16'h0000,0, 0,1,0,0, 0,0,6,0);
    vecs[8]  = mk(1,0,16'h0000,0, 0,1,0,0, 0,0,7,0);
    vecs[9]  = mk(1,0,16'h0000,0, 0,1,0,0, 1,2,0,1);
    vecs[10] = mk(0,0,16'h0000,0, 0,0,0,3, 2,2,0,0);
    vecs[11] = mk(0,0,16'h0000,0, 0,0,0,2, 3,2,0,0);
    vecs[12] = mk(0,0,16'h0000,0, 0,0,0,7, 1,2,0,0);
    vecs[13] = mk(1,0,16'h0000,0, 0,0,0,3, 2,2,1,0);
    vecs[14] = mk(1,0,16'h0000,0, 0,0,0,3, 3,2,2,0);
    vecs[15] = mk(1,0,16'h0000,0, 0,0,0,3, 0,2,3,0);
    vecs[16] = mk(1,0,16'h0000,0, 0,0,0,3, 1,2,4,0);
    vecs[17] = mk(1,0,16'h0000,0, 0,0,0,3, 1,1,5,0);
    vecs[18] = mk(1,1,16'h810F,3, 0,1,0,0, 0,2,6,0);
    vecs[19] = mk(1,0,16'h0000,0, 0,1,0,0, 1,2,7,0);
    vecs[20] = mk(1,1,16'hFFFF,0, 1,1,0,0, 1,1,0,1);
    vecs[21] = mk(0,0,16'h0000,0, 0,0,0,0, 1,1,0,0);
    vecs[22] = mk(1,0,16'h0000,0, 0,0,0,7, 2,3,1,0);
    vecs[23] = mk(1,0,16'h0000,0, 0,0,1,7, 0,3,0,0);
    vecs[24] = mk(0,0,16'h0000,0, 1,0,0,0, 1,1,0,1);

    // Reset held while shifting must keep everything at zero.
    reset = 1'b1;
    drive(mk(1,0,16'h0000,0, 0,1,0,0, 0,0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      check_outs("vec", i, vecs[i].e_pix, vecs[i].e_pal, vecs[i].e_ph, vecs[i].e_pul);
    end

    // Asynchronous reset mid-tile clears state without waiting for an edge.
    drive(mk(0,0,16'h0000,0, 0,0,0,0, 0,0,0,0));
    #2 reset = 1'b1;
    #1 check_outs("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Staging was cleared too, so a bare reload brings in an empty tile.
    drive(mk(0,0,16'h0000,0, 1,0,0,0, 0,0,0,0));
    @(posedge clk);
    @(negedge clk);
    check_outs("post_rst_load", 0, 0, 0, 0, 1);
    bus.i_load_en = 1'b0;
    bus.i_fine_x  = 3'd7;
    #1 chk("post_rst_fx7.pixel", 0, 8'(bus.o_pixel_out), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
